// File: rtl/intc_prio.sv
// Prioritised interrupt controller: latches irq edges, grants the highest eligible channel above the in-service level via registered req/ack.
// Latency: irq edge -> pending 1 cycle, pending -> irq_req 1 cycle; at least one idle cycle between grants. Backpressure: irq_vec holds until int_ack.
// INTC_NEST_EN: defined = nested preemption by priority; undefined = one interrupt in service at a time.
module intc_prio #(
    parameter int NCH = 8,
    parameter int IDW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] irq,
    input  logic [NCH-1:0] mask,
    input  logic           int_ack,
    input  logic           reti,
    output logic           irq_req,
    output logic [NCH-1:0] irq_vec,
    output logic [IDW-1:0] irq_id,
    output logic [NCH-1:0] isr,
    output logic [NCH-1:0] reti_vec,
    output logic [NCH-1:0] pending
);

    localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           req_q, req_d;
    logic [NCH-1:0] vec_q, vec_d;
    logic [IDW-1:0] id_q, id_d;
    logic [NCH-1:0] irq_d_q;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] isr_q, isr_d;
    logic [NCH-1:0] reti_vec_q, reti_vec_d;

    logic [NCH-1:0] rise;
    logic [NCH-1:0] eligible;
    logic [NCH-1:0] cand_oh;
    logic [IDW-1:0] cand_idx;
    logic [NCH-1:0] isr_top;
    logic           cand_hit;
    logic           cand_ok;
    logic           reti_fire;
    logic [NCH-1:0] retire;
    logic [NCH-1:0] grant_oh;

    assign rise      = irq & ~irq_d_q;
    assign eligible  = pending_q & mask;
    assign cand_hit  = |eligible;
    assign reti_fire = reti && (|isr_q);

    // Highest set bit wins, both for the candidate and the in-service level.
    always_comb begin
        cand_oh  = '0;
        cand_idx = '0;
        isr_top  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (eligible[i]) begin
                cand_oh  = ONE << i;
                cand_idx = IDW'(i);
            end
            if (isr_q[i]) begin
                isr_top = ONE << i;
            end
        end
    end

`ifdef INTC_NEST_EN
    assign cand_ok = cand_hit && (cand_oh > isr_top);
    assign retire  = reti_fire ? isr_top : '0;
`else
    assign cand_ok = cand_hit && (isr_top == '0);
    assign retire  = reti_fire ? isr_q : '0;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vec_d    = vec_q;
        id_d     = id_q;
        grant_oh = '0;
        case (state_q)
            ST_IDLE: begin
                if (cand_ok) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = cand_oh;
                    id_d    = cand_idx;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    vec_d    = '0;
                    id_d     = '0;
                    grant_oh = vec_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge on the granted channel survives the acknowledge.
        pending_d  = (pending_q & ~grant_oh) | rise;
        isr_d      = (isr_q & ~retire) | grant_oh;
        reti_vec_d = retire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            vec_q      <= '0;
            id_q       <= '0;
            irq_d_q    <= '0;
            pending_q  <= '0;
            isr_q      <= '0;
            reti_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            vec_q      <= vec_d;
            id_q       <= id_d;
            irq_d_q    <= irq;
            pending_q  <= pending_d;
            isr_q      <= isr_d;
            reti_vec_q <= reti_vec_d;
        end
    end

    assign irq_req  = req_q;
    assign irq_vec  = vec_q;
    assign irq_id   = id_q;
    assign isr      = isr_q;
    assign reti_vec = reti_vec_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_intc_prio.sv
// Bench for intc_prio: expected grants queued at stimulus time and popped when irq_req rises.
module tb_intc_prio;
    localparam int NCH = 8;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] irq;
    logic [NCH-1:0] mask;
    logic           int_ack;
    logic           reti;
    logic           irq_req;
    logic [NCH-1:0] irq_vec;
    logic [IDW-1:0] irq_id;
    logic [NCH-1:0] isr;
    logic [NCH-1:0] reti_vec;
    logic [NCH-1:0] pending;

    logic [NCH-1:0] exp_q[$];
    logic [NCH-1:0] exp_v;
    int n_cmp = 0;
    int n_bad = 0;

    intc_prio #(.NCH(NCH), .IDW(IDW)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .mask    (mask),
        .int_ack (int_ack),
        .reti    (reti),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_id  (irq_id),
        .isr     (isr),
        .reti_vec(reti_vec),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic apply_reset();
        reset = 1'b0; irq = '0; mask = '1; int_ack = 1'b0; reti = 1'b0;
        exp_q.delete();
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_irq(input logic [NCH-1:0] v);
        irq = v;
        step();
        irq = '0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", irq_req); end
        n_cmp++; if ({irq_vec, irq_id} !== '0) begin n_bad++; $display("FAIL reset_vec_id: got %h/%0d want 0/0", irq_vec, irq_id); end
        n_cmp++; if ({isr, reti_vec, pending} !== '0) begin n_bad++; $display("FAIL reset_state: isr %h reti_vec %h pending %h want all 0", isr, reti_vec, pending); end
    endtask

    task automatic test_basic();
        apply_reset();
        exp_q.push_back(8'h04);
        pulse_irq(8'h04);
        n_cmp++; if (pending !== 8'h04) begin n_bad++; $display("FAIL basic_pending: got %h want 04", pending); end
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_early: got %b want 0", irq_req); end
        step();
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL basic_req: got %b want 1", irq_req); end
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL basic_vec: got %h want %h", irq_vec, exp_v); end
        n_cmp++; if (irq_id !== 3'd2) begin n_bad++; $display("FAIL basic_id: got %0d want 2", irq_id); end
        do_ack();
        n_cmp++; if (isr !== 8'h04) begin n_bad++; $display("FAIL basic_isr: got %h want 04", isr); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL basic_pending_clr: got %h want 00", pending); end
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL basic_req_drop: got %b want 0", irq_req); end
    endtask

    task automatic test_nest_block();
        apply_reset();
        exp_q.push_back(8'h04);
        pulse_irq(8'h04);
        step();
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL nest_first_vec: got %h want %h", irq_vec, exp_v); end
        do_ack();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h02);
        pulse_irq(8'h42);
        n_cmp++; if (pending !== 8'h42) begin n_bad++; $display("FAIL nest_pending: got %h want 42", pending); end
`ifdef INTC_NEST_EN
        step();
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL nest_preempt_req: got %b want 1", irq_req); end
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL nest_preempt_vec: got %h want %h", irq_vec, exp_v); end
        n_cmp++; if (irq_id !== 3'd6) begin n_bad++; $display("FAIL nest_preempt_id: got %0d want 6", irq_id); end
        do_ack();
        n_cmp++; if (isr !== 8'h44) begin n_bad++; $display("FAIL nest_isr2: got %h want 44", isr); end
        step();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL nest_low_blocked: got %b want 0", irq_req); end
        do_reti();
        n_cmp++; if (reti_vec !== 8'h40) begin n_bad++; $display("FAIL nest_reti1_vec: got %h want 40", reti_vec); end
        n_cmp++; if (isr !== 8'h04) begin n_bad++; $display("FAIL nest_reti1_isr: got %h want 04", isr); end
        step();
        n_cmp++; if ({irq_req, reti_vec} !== 9'h000) begin n_bad++; $display("FAIL nest_still_blocked: req %b reti_vec %h want 0/00", irq_req, reti_vec); end
        do_reti();
        n_cmp++; if (reti_vec !== 8'h04) begin n_bad++; $display("FAIL nest_reti2_vec: got %h want 04", reti_vec); end
        step();
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL nest_low_req: got %b want 1", irq_req); end
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL nest_low_vec: got %h want %h", irq_vec, exp_v); end
`else
        repeat (3) step();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL flat_blocked: got %b want 0", irq_req); end
        do_reti();
        n_cmp++; if (reti_vec !== 8'h04) begin n_bad++; $display("FAIL flat_reti_vec: got %h want 04", reti_vec); end
        n_cmp++; if (isr !== 8'h00) begin n_bad++; $display("FAIL flat_reti_isr: got %h want 00", isr); end
        step();
        n_cmp++; if (reti_vec !== 8'h00) begin n_bad++; $display("FAIL flat_reti_pulse: got %h want 00", reti_vec); end
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL flat_req_after_reti: got %b want 1", irq_req); end
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL flat_vec_hi: got %h want %h", irq_vec, exp_v); end
        do_ack();
        n_cmp++; if ({isr, pending} !== 16'h4002) begin n_bad++; $display("FAIL flat_isr_pending: isr %h pending %h want 40/02", isr, pending); end
        do_reti();
        n_cmp++; if (reti_vec !== 8'h40) begin n_bad++; $display("FAIL flat_reti2_vec: got %h want 40", reti_vec); end
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec} !== {1'b1, exp_v}) begin n_bad++; $display("FAIL flat_vec_lo: req %b vec %h want 1/%h", irq_req, irq_vec, exp_v); end
`endif
    endtask

    task automatic test_freeze();
        apply_reset();
        exp_q.push_back(8'h02);
        pulse_irq(8'h02);
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec} !== {1'b1, exp_v}) begin n_bad++; $display("FAIL freeze_first: req %b vec %h want 1/%h", irq_req, irq_vec, exp_v); end
        exp_q.push_back(8'h80);
        mask = 8'h00;
        pulse_irq(8'h80);
        n_cmp++; if ({irq_vec, irq_id} !== {8'h02, 3'd1}) begin n_bad++; $display("FAIL freeze_vec: got %h/%0d want 02/1", irq_vec, irq_id); end
        n_cmp++; if (pending !== 8'h82) begin n_bad++; $display("FAIL freeze_pending: got %h want 82", pending); end
        mask = '1;
        step();
        n_cmp++; if (irq_vec !== 8'h02) begin n_bad++; $display("FAIL freeze_vec_hold: got %h want 02", irq_vec); end
        do_ack();
        n_cmp++; if ({isr, pending, irq_req} !== {8'h02, 8'h80, 1'b0}) begin n_bad++; $display("FAIL freeze_ack: isr %h pending %h req %b want 02/80/0", isr, pending, irq_req); end
`ifdef INTC_NEST_EN
        step();
`else
        step();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL freeze_flat_blocked: got %b want 0", irq_req); end
        do_reti();
        step();
`endif
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec, irq_id} !== {1'b1, exp_v, 3'd7}) begin n_bad++; $display("FAIL freeze_second: req %b vec %h id %0d want 1/%h/7", irq_req, irq_vec, irq_id, exp_v); end
    endtask

    task automatic test_mask();
        apply_reset();
        mask = 8'hF7;
        pulse_irq(8'h08);
        repeat (3) step();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL mask_blocked: got %b want 0", irq_req); end
        n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL mask_pending: got %h want 08", pending); end
        exp_q.push_back(8'h08);
        mask = '1;
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec, irq_id} !== {1'b1, exp_v, 3'd3}) begin n_bad++; $display("FAIL mask_release: req %b vec %h id %0d want 1/%h/3", irq_req, irq_vec, irq_id, exp_v); end
    endtask

    task automatic test_ignored();
        apply_reset();
        do_reti();
        n_cmp++; if ({reti_vec, isr} !== 16'h0000) begin n_bad++; $display("FAIL reti_empty: reti_vec %h isr %h want 00/00", reti_vec, isr); end
        exp_q.push_back(8'h01);
        pulse_irq(8'h01);
        do_ack();
        n_cmp++; if ({irq_req, pending, isr} !== {1'b1, 8'h01, 8'h00}) begin n_bad++; $display("FAIL ack_idle: req %b pending %h isr %h want 1/01/00", irq_req, pending, isr); end
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL ack_idle_vec: got %h want %h", irq_vec, exp_v); end
        int_ack = 1'b1; irq = 8'h01;
        step();
        int_ack = 1'b0; irq = '0;
        n_cmp++; if ({isr, pending} !== 16'h0101) begin n_bad++; $display("FAIL set_wins: isr %h pending %h want 01/01", isr, pending); end
        step();
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL same_level_blocked: got %b want 0", irq_req); end
    endtask

    task automatic test_ack_reti();
        apply_reset();
        exp_q.push_back(8'h10);
        pulse_irq(8'h10);
        step();
        exp_v = pop_exp();
        n_cmp++; if (irq_vec !== exp_v) begin n_bad++; $display("FAIL ackreti_first: got %h want %h", irq_vec, exp_v); end
        do_ack();
        exp_q.push_back(8'h80);
        pulse_irq(8'h80);
`ifdef INTC_NEST_EN
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec} !== {1'b1, exp_v}) begin n_bad++; $display("FAIL ackreti_grant: req %b vec %h want 1/%h", irq_req, irq_vec, exp_v); end
        int_ack = 1'b1; reti = 1'b1;
        step();
        int_ack = 1'b0; reti = 1'b0;
        n_cmp++; if (isr !== 8'h80) begin n_bad++; $display("FAIL ackreti_isr: got %h want 80", isr); end
        n_cmp++; if (reti_vec !== 8'h10) begin n_bad++; $display("FAIL ackreti_vec: got %h want 10", reti_vec); end
`else
        do_reti();
        n_cmp++; if ({isr, reti_vec} !== 16'h0010) begin n_bad++; $display("FAIL ackreti_flat_reti: isr %h reti_vec %h want 00/10", isr, reti_vec); end
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec} !== {1'b1, exp_v}) begin n_bad++; $display("FAIL ackreti_grant: req %b vec %h want 1/%h", irq_req, irq_vec, exp_v); end
        int_ack = 1'b1; reti = 1'b1;
        step();
        int_ack = 1'b0; reti = 1'b0;
        n_cmp++; if (isr !== 8'h80) begin n_bad++; $display("FAIL ackreti_isr: got %h want 80", isr); end
        n_cmp++; if (reti_vec !== 8'h00) begin n_bad++; $display("FAIL ackreti_vec: got %h want 00", reti_vec); end
`endif
        step();
        n_cmp++; if (reti_vec !== 8'h00) begin n_bad++; $display("FAIL ackreti_pulse_end: got %h want 00", reti_vec); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        exp_q.push_back(8'h20);
        pulse_irq(8'h20);
        step();
        exp_v = pop_exp();
        n_cmp++; if ({irq_req, irq_vec} !== {1'b1, exp_v}) begin n_bad++; $display("FAIL rstmid_req: req %b vec %h want 1/%h", irq_req, irq_vec, exp_v); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if ({irq_req, irq_vec, irq_id} !== '0) begin n_bad++; $display("FAIL rstmid_async: req %b vec %h id %0d want 0", irq_req, irq_vec, irq_id); end
        n_cmp++; if ({isr, reti_vec, pending} !== '0) begin n_bad++; $display("FAIL rstmid_state: isr %h reti_vec %h pending %h want 0", isr, reti_vec, pending); end
        #1 reset = 1'b1;
        repeat (4) step();
        n_cmp++; if ({irq_req, pending} !== 9'h000) begin n_bad++; $display("FAIL rstmid_no_replay: req %b pending %h want 0/00", irq_req, pending); end
    endtask

    initial begin
        reset = 1'b0; irq = '0; mask = '1; int_ack = 1'b0; reti = 1'b0;
        test_reset();
        test_basic();
        test_nest_block();
        test_freeze();
        test_mask();
        test_ignored();
        test_ack_reti();
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
